// File: rtl/mem_port_arb_if.sv
// Bundle for the shared-memory arbiter: core and loader request ports, the memory port and the grant indicator.
// The arbiter connects as slave; the requesters/memory side connects as master.
interface mem_port_arb_if;
   logic        core_req;
   logic        core_we;
   logic [31:0] core_addr;
   logic [31:0] core_wdata;
   logic [31:0] core_rdata;
   logic        core_ready;

   logic        ld_req;
   logic        ld_we;
   logic [31:0] ld_addr;
   logic [31:0] ld_wdata;
   logic [31:0] ld_rdata;
   logic        ld_ready;

   logic        mem_en;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   logic        owner;

   modport slave (
      input  core_req, core_we, core_addr, core_wdata,
      output core_rdata, core_ready,
      input  ld_req, ld_we, ld_addr, ld_wdata,
      output ld_rdata, ld_ready,
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata,
      output owner
   );

   modport master (
      output core_req, core_we, core_addr, core_wdata,
      input  core_rdata, core_ready,
      output ld_req, ld_we, ld_addr, ld_wdata,
      input  ld_rdata, ld_ready,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata,
      input  owner
   );
endinterface

// File: rtl/mem_port_arb.sv
// Two-port arbiter (core vs. program loader) in front of a single shared memory with a fixed
// multicycle access time; ties alternate between requesters.
module mem_port_arb #(
   parameter int WAIT_CYCLES = 1
) (
   input logic           clk,
   input logic           reset,
   mem_port_arb_if.slave bus
);

   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t      state;
   state_t      state_nxt;
   logic [3:0]  cnt;
   logic        owner_q;
   logic        we_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] rdata_q;
   logic        any_req;
   logic        grant_ld;

   // Loader wins alone, or on a tie when the core held the last grant.
   assign any_req  = bus.core_req | bus.ld_req;
   assign grant_ld = (bus.core_req & bus.ld_req) ? ~owner_q : bus.ld_req;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (any_req) state_nxt = ACCESS;
         ACCESS:  if (cnt == 4'd0) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt     <= 4'd0;
         owner_q <= 1'b1;
         we_q    <= 1'b0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         rdata_q <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  owner_q <= grant_ld;
                  we_q    <= grant_ld ? bus.ld_we    : bus.core_we;
                  addr_q  <= grant_ld ? bus.ld_addr  : bus.core_addr;
                  wdata_q <= grant_ld ? bus.ld_wdata : bus.core_wdata;
                  cnt     <= WAIT_INIT;
               end
            end
            ACCESS: begin
               // Memory data is valid on the last access cycle, read or write alike.
               if (cnt == 4'd0) rdata_q <= bus.mem_rdata;
               else             cnt     <= cnt - 4'd1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      bus.mem_en     = 1'b0;
      bus.mem_we     = 1'b0;
      bus.core_ready = 1'b0;
      bus.ld_ready   = 1'b0;
      case (state)
         ACCESS: begin
            bus.mem_en = 1'b1;
            bus.mem_we = we_q & (cnt == 4'd0);
         end
         RESP: begin
            bus.core_ready = ~owner_q;
            bus.ld_ready   = owner_q;
         end
         default: ;
      endcase
   end

   assign bus.mem_addr   = addr_q;
   assign bus.mem_wdata  = wdata_q;
   assign bus.core_rdata = rdata_q;
   assign bus.ld_rdata   = rdata_q;
   assign bus.owner      = owner_q;

endmodule

// File: doc/mem_port_arb.md
MEM_PORT_ARB -- requirements
Module: mem_port_arb

Interface
REQ-001 The block SHALL have parameter WAIT_CYCLES, default 1, giving the extra memory access cycles beyond the first (legal range 0..15).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port core_req, input, 1, core access request, held until core_ready.
REQ-005 The block SHALL have port core_we, input, 1, core write enable, where 1 means write.
REQ-006 The block SHALL have ports core_addr and core_wdata, input, 32 each, carrying the core address and write data.
REQ-007 The block SHALL have port core_rdata, output, 32, read data, valid only while core_ready=1.
REQ-008 The block SHALL have port core_ready, output, 1, a one-cycle completion pulse; the multicycle core stalls while core_req=1 and core_ready=0.
REQ-009 The block SHALL have ports ld_req, ld_we, ld_addr[31:0], ld_wdata[31:0], ld_rdata[31:0] and ld_ready, with the same directions, widths and meanings for the program loader/debug port.
REQ-010 The block SHALL have ports mem_en, mem_we, mem_addr[31:0] and mem_wdata[31:0], outputs, driving the single shared instruction/data memory.
REQ-011 The block SHALL have port mem_rdata, input, 32, memory read data, valid during the final ACCESS cycle.
REQ-012 The block SHALL have port owner, output, 1, the current or last grant, where 0 means core and 1 means loader.

Function
REQ-013 The block SHALL implement FSM states IDLE, ACCESS and RESP, with a 4-bit wait counter.
REQ-014 In IDLE with any request high, the block SHALL at the clock edge latch the winner's addr, we and wdata, set owner, load the counter with WAIT_CYCLES and go to ACCESS.
REQ-015 Arbitration SHALL be as follows: with one requester, that requester is granted; with both requesting, the one not granted last is granted, so a tie alternates.
REQ-016 In ACCESS the block SHALL hold mem_en=1 and drive mem_addr and mem_wdata from the latched values.
REQ-017 In ACCESS the block SHALL assert mem_we only on the final ACCESS cycle (counter==0) and only when latched we=1.
REQ-018 In ACCESS the counter SHALL decrement each cycle; at counter==0 the block SHALL capture mem_rdata into the rdata register and go to RESP.
REQ-019 ACCESS SHALL last exactly WAIT_CYCLES+1 cycles; WAIT_CYCLES=0 gives a single ACCESS cycle.
REQ-020 In RESP the block SHALL assert the owner's ready for exactly one cycle, drive rdata to both rdata outputs and return to IDLE.
REQ-021 Latency SHALL be: a request in IDLE cycle t produces its ready pulse in cycle t+WAIT_CYCLES+2.
REQ-022 Requests SHALL be sampled only in IDLE; a request held during ACCESS or RESP waits, costing one IDLE cycle between back-to-back transactions.
REQ-023 If a requester drops its req mid-transaction, the transaction SHALL still complete; its write is committed and its ready still pulses.
REQ-024 The non-owner's ready SHALL remain 0 throughout.
REQ-025 For a write, rdata SHALL be updated with mem_rdata as for a read, and its value is don't-care.
REQ-026 mem_en and mem_we SHALL be 0 in IDLE and RESP.

Reset
REQ-027 On reset=1 the block SHALL, asynchronously, set state=IDLE, counter=0, owner=1 (loader last, so the core wins the first tie), and the rdata, mem_addr and mem_wdata registers to 0.
REQ-028 On reset=1 the block SHALL, asynchronously, drive all ready, mem_en and mem_we outputs to 0.
REQ-029 Reset during ACCESS SHALL abort the transaction: no mem_we pulse occurs and no ready pulse occurs.
REQ-030 After reset deasserts, the first request SHALL be sampled on the first rising edge.

Verification
REQ-031 Core read with WAIT_CYCLES=1: core_req=1, core_addr=0x10 and memory[0x10]=0x8C020004 -> mem_en high for 2 cycles and core_ready=1 with core_rdata=0x8C020004 in cycle t+3.
REQ-032 Loader write with WAIT_CYCLES=2: ld_we=1, ld_addr=0x20 and ld_wdata=0xDEADBEEF -> mem_we high only in the 3rd ACCESS cycle, ld_ready in t+4, and memory[0x20]=0xDEADBEEF.
REQ-033 Simultaneous requests held continuously from reset -> grants alternate core, loader, core, loader, with owner toggling and each requester's ready pulsing every 2*(WAIT_CYCLES+3) cycles.
REQ-034 Reset asserted in the 1st ACCESS cycle of a write with WAIT_CYCLES=3 -> mem_en and mem_we drop immediately, the memory location is unchanged and no ready pulse occurs.
REQ-035 WAIT_CYCLES=0 with back-to-back core requests -> ready pulses at cycles t+2, t+5 and t+8, with mem_en high for 1 cycle each.
